// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM. Sequences FETCH/DECODE/EXECUTE/
// MEMORY/WRITEBACK and drives every datapath select and write enable.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   opcode, funct   IR[31:26] and IR[5:0], stable for the whole instruction
//   zero            ALU zero flag (beq condition)
//   mem_ready       memory access completes this cycle
//   pc_write/pc_src, ir_write, reg_write/reg_dst/mem_to_reg,
//   alu_src_a/alu_src_b/alu_op/ext_op, mem_read/mem_write
//                   datapath controls
//   instr_done      one-cycle pulse in the last cycle of each instruction
//   state           current state code (debug)
//
// Build option: MC_CTRL_MEM_WAIT_EN
//   defined   FETCH/MEM_RD/MEM_WR wait for mem_ready
//   undefined mem_ready is ignored; every memory state lasts one cycle

module mc_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter logic [4:0] JAL_REG     = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  // reg_dst=2 is hardwired to $31 in the datapath; any other
  // link register would need a datapath change as well.
  if (JAL_REG != 5'd31) begin : g_jal_reg_chk
    $error("mc_ctrl_fsm: datapath only supports JAL_REG=31");
  end

  state_t cur;
  logic   wb_rd;
  logic   rdy;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  logic is_r;
  logic is_addu;
  logic is_subu;
  logic is_jr;
  logic is_ori;
  logic is_lui;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_jal;
  logic cls_r;
  logic cls_i;
  logic cls_m;
  logic cls_j;

  assign is_r    = (opcode == OP_R);
  assign is_addu = is_r && (funct == FN_ADDU);
  assign is_subu = is_r && (funct == FN_SUBU);
  assign is_jr   = is_r && (funct == FN_JR);
  assign is_ori  = (opcode == OP_ORI);
  assign is_lui  = (opcode == OP_LUI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);

  assign cls_r = is_addu | is_subu;
  assign cls_i = is_ori | is_lui;
  assign cls_m = is_lw | is_sw;
  assign cls_j = is_j | is_jal;

  // wb_rd remembers, from DECODE, whether WB_ALU writes rd (R-type)
  // or rt (immediate ops).
  always_ff @(posedge clk) begin
    if (reset) begin
      cur   <= state_t'(RESET_STATE);
      wb_rd <= 1'b0;
    end else begin
      unique case (cur)
        S_FETCH: begin
          if (rdy) cur <= S_DECODE;
        end
        S_DECODE: begin
          wb_rd <= cls_r;
          unique case (1'b1)
            cls_r:   cur <= S_EXE_R;
            cls_i:   cur <= S_EXE_I;
            cls_m:   cur <= S_MEM_ADDR;
            is_beq:  cur <= S_BRANCH;
            cls_j:   cur <= S_JUMP;
            default: cur <= S_FETCH;
          endcase
        end
        S_EXE_R:    cur <= S_WB_ALU;
        S_EXE_I:    cur <= S_WB_ALU;
        S_MEM_ADDR: cur <= is_lw ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (rdy) cur <= S_WB_MEM;
        end
        S_MEM_WR: begin
          if (rdy) cur <= S_FETCH;
        end
        S_WB_ALU:   cur <= S_FETCH;
        S_WB_MEM:   cur <= S_FETCH;
        S_BRANCH:   cur <= S_FETCH;
        S_JUMP:     cur <= S_FETCH;
        default:    cur <= S_FETCH;
      endcase
    end
  end

  assign state = cur;

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;

    unique case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      S_DECODE: begin
        // branch target PC+4+(imm<<2) goes to ALUOut here
        alu_src_b = 2'd3;
        ext_op    = 1'b1;
        if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
        end
        // jr and unsupported encodings finish in DECODE
        instr_done = ~(cls_r | cls_i | cls_m | is_beq | cls_j);
      end
      S_EXE_R: begin
        alu_src_a = 1'b1;
        alu_op    = is_subu ? ALU_SUB : ALU_ADD;
      end
      S_EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = is_ori ? ALU_OR : ALU_LUI;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        instr_done = rdy;
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = wb_rd ? 2'd1 : 2'd0;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        // PC still holds PC+4, so mem_to_reg=2 links the return address
        if (is_jal) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      default: ;
    endcase

    // reset abandons the instruction with no further side effects
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized scoreboard bench for mc_ctrl_fsm.
// Stimulus pushes expected per-cycle controls and latencies; a monitor checks.

module tb_mc_ctrl_fsm;

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
  } ctl_t;

  typedef enum int {
    K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW,
    K_SW, K_BEQ, K_J, K_JAL, K_NOP
  } kind_t;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       ext_op;
  logic       mem_read;
  logic       mem_write;
  logic       instr_done;
  logic [3:0] state;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_op(ext_op), .mem_read(mem_read), .mem_write(mem_write),
    .instr_done(instr_done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t exp_q[$];
  int   lat_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cnt = 0;
  bit   done = 1'b0;
  ctl_t got_v;
  ctl_t exp_v;
  int   lat_v;

  // unsupported encodings: {opcode,funct}
  logic [11:0] nops [6] = '{12'hFC0, 12'h200, 12'h300,
                            12'h020, 12'h000, 12'h02A};

  // ---------------- reference model: expected controls per step

  function automatic ctl_t base(input logic [3:0] s);
    ctl_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  function automatic ctl_t rmask(input ctl_t e);
    ctl_t c;
    c = e;
    c.pc_write = 0; c.ir_write = 0; c.reg_write = 0;
    c.mem_read = 0; c.mem_write = 0; c.instr_done = 0;
    return c;
  endfunction

  function automatic ctl_t m_fetch(input logic r);
    ctl_t c;
    c = base(4'd0);
    c.mem_read = 1; c.alu_src_b = 2'd1;
    c.ir_write = r; c.pc_write = r;
    return c;
  endfunction

  function automatic ctl_t m_decode(input kind_t k);
    ctl_t c;
    c = base(4'd1);
    c.alu_src_b = 2'd3; c.ext_op = 1;
    if (k == K_JR) begin
      c.pc_write = 1; c.pc_src = 2'd3; c.instr_done = 1;
    end
    if (k == K_NOP) c.instr_done = 1;
    return c;
  endfunction

  function automatic ctl_t m_exe_r(input kind_t k);
    ctl_t c;
    c = base(4'd2);
    c.alu_src_a = 1;
    c.alu_op = (k == K_SUBU) ? 3'd1 : 3'd0;
    return c;
  endfunction

  function automatic ctl_t m_exe_i(input kind_t k);
    ctl_t c;
    c = base(4'd3);
    c.alu_src_a = 1; c.alu_src_b = 2'd2;
    c.alu_op = (k == K_ORI) ? 3'd2 : 3'd3;
    return c;
  endfunction

  function automatic ctl_t m_mem_addr();
    ctl_t c;
    c = base(4'd4);
    c.alu_src_a = 1; c.alu_src_b = 2'd2; c.ext_op = 1;
    return c;
  endfunction

  function automatic ctl_t m_mem_rd();
    ctl_t c;
    c = base(4'd5);
    c.mem_read = 1;
    return c;
  endfunction

  function automatic ctl_t m_mem_wr(input logic r);
    ctl_t c;
    c = base(4'd6);
    c.mem_write = 1; c.instr_done = r;
    return c;
  endfunction

  function automatic ctl_t m_wb_alu(input kind_t k);
    ctl_t c;
    c = base(4'd7);
    c.reg_write = 1; c.instr_done = 1;
    c.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    return c;
  endfunction

  function automatic ctl_t m_wb_mem();
    ctl_t c;
    c = base(4'd8);
    c.reg_write = 1; c.mem_to_reg = 2'd1; c.instr_done = 1;
    return c;
  endfunction

  function automatic ctl_t m_branch(input logic z);
    ctl_t c;
    c = base(4'd9);
    c.alu_src_a = 1; c.alu_op = 3'd1; c.pc_src = 2'd1;
    c.pc_write = z; c.instr_done = 1;
    return c;
  endfunction

  function automatic ctl_t m_jump(input kind_t k);
    ctl_t c;
    c = base(4'd10);
    c.pc_src = 2'd2; c.pc_write = 1; c.instr_done = 1;
    if (k == K_JAL) begin
      c.reg_write = 1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
    end
    return c;
  endfunction

  function automatic int lat_base(input kind_t k);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW: return 4;
      K_LW:                               return 5;
      K_BEQ, K_J, K_JAL:                  return 3;
      default:                            return 2;
    endcase
  endfunction

  function automatic bit rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic void enc(input kind_t k, input int nsel,
                              output logic [5:0] op,
                              output logic [5:0] fn);
    int s;
    fn = 6'($urandom);
    op = 6'h00;
    case (k)
      K_ADDU: fn = 6'h21;
      K_SUBU: fn = 6'h23;
      K_JR:   fn = 6'h08;
      K_ORI:  op = 6'h0D;
      K_LUI:  op = 6'h0F;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      default: begin
        s = (nsel < 0) ? int'($urandom_range(0, 5)) : nsel;
        {op, fn} = nops[s];
      end
    endcase
  endfunction

  // ---------------- stimulus

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn,
                     input logic mr, input logic z,
                     input logic rs, input ctl_t e);
    @(posedge clk);
    #1;
    opcode = op; funct = fn; mem_ready = mr; zero = z; reset = rs;
    exp_q.push_back(rs ? rmask(e) : e);
  endtask

  task automatic mem_phase(input logic [5:0] op, input logic [5:0] fn,
                           input ctl_t stall_e, input ctl_t go_e,
                           input int w);
    if (WAIT_EN) begin
      for (int i = 0; i < w; i++)
        cyc(op, fn, 1'b0, rb(), 1'b0, stall_e);
      cyc(op, fn, 1'b1, rb(), 1'b0, go_e);
    end else begin
      cyc(op, fn, rb(), rb(), 1'b0, go_e);
    end
  endtask

  task automatic run_instr(input kind_t k, input logic z,
                           input int wf, input int wm, input int nsel);
    logic [5:0] op;
    logic [5:0] fn;
    enc(k, nsel, op, fn);
    if (!WAIT_EN) begin
      wf = 0;
      wm = 0;
    end
    lat_q.push_back(lat_base(k) + wf +
                    ((k == K_LW || k == K_SW) ? wm : 0));
    mem_phase(op, fn, m_fetch(1'b0), m_fetch(1'b1), wf);
    cyc(op, fn, rb(), rb(), 1'b0, m_decode(k));
    case (k)
      K_ADDU, K_SUBU: begin
        cyc(op, fn, rb(), rb(), 1'b0, m_exe_r(k));
        cyc(op, fn, rb(), rb(), 1'b0, m_wb_alu(k));
      end
      K_ORI, K_LUI: begin
        cyc(op, fn, rb(), rb(), 1'b0, m_exe_i(k));
        cyc(op, fn, rb(), rb(), 1'b0, m_wb_alu(k));
      end
      K_LW: begin
        cyc(op, fn, rb(), rb(), 1'b0, m_mem_addr());
        mem_phase(op, fn, m_mem_rd(), m_mem_rd(), wm);
        cyc(op, fn, rb(), rb(), 1'b0, m_wb_mem());
      end
      K_SW: begin
        cyc(op, fn, rb(), rb(), 1'b0, m_mem_addr());
        mem_phase(op, fn, m_mem_wr(1'b0), m_mem_wr(1'b1), wm);
      end
      K_BEQ: cyc(op, fn, rb(), z, 1'b0, m_branch(z));
      K_J, K_JAL: cyc(op, fn, rb(), rb(), 1'b0, m_jump(k));
      default: ;
    endcase
  endtask

  // sw interrupted by reset while in MEM_WR; no completion expected
  task automatic sw_abort(input int wm);
    logic [5:0] op;
    logic [5:0] fn;
    enc(K_SW, -1, op, fn);
    mem_phase(op, fn, m_fetch(1'b0), m_fetch(1'b1), 0);
    cyc(op, fn, rb(), rb(), 1'b0, m_decode(K_SW));
    cyc(op, fn, rb(), rb(), 1'b0, m_mem_addr());
    if (WAIT_EN)
      for (int i = 0; i < wm; i++)
        cyc(op, fn, 1'b0, rb(), 1'b0, m_mem_wr(1'b0));
    cyc(op, fn, rb(), rb(), 1'b1, m_mem_wr(1'b0));
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(6'h00, 6'h00, rb(), rb(), 1'b1, m_fetch(1'b1));
    run_instr(K_ADDU, 1'b0, 0, 0, -1);
    run_instr(K_LW, 1'b0, 0, 2, -1);
    run_instr(K_BEQ, 1'b1, 0, 0, -1);
    run_instr(K_BEQ, 1'b0, 0, 0, -1);
    run_instr(K_JAL, 1'b0, 0, 0, -1);
    run_instr(K_JR, 1'b0, 0, 0, -1);
    run_instr(K_NOP, 1'b0, 0, 0, 0);
    sw_abort(1);
    run_instr(K_SUBU, 1'b0, 1, 0, -1);
    run_instr(K_ORI, 1'b0, 0, 0, -1);
    run_instr(K_LUI, 1'b0, 2, 0, -1);
    run_instr(K_SW, 1'b0, 0, 3, -1);
    run_instr(K_J, 1'b0, 0, 0, -1);
    run_instr(K_NOP, 1'b0, 0, 3, 3);
    for (int n = 0; n < 250; n++) begin
      if (n % 41 == 40)
        sw_abort(int'($urandom_range(0, 2)));
      else
        run_instr(kind_t'($urandom_range(0, 10)), rb(),
                  int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), -1);
    end
    for (int i = 0; i < 2; i++)
      cyc(6'h00, 6'h00, rb(), rb(), 1'b1, m_fetch(1'b1));
    @(posedge clk);
    #1;
    done = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "bench timeout");
  end

  // ---------------- monitor / scoreboard

  always @(negedge clk) begin
    got_v = '{state, pc_write, pc_src, ir_write, reg_write, reg_dst,
              mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op,
              mem_read, mem_write, instr_done};
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL ctl t=%0t st=%0d got=%h exp=%h",
                 $time, exp_v.st, got_v, exp_v);
      end
    end
    if (reset) begin
      cnt = 0;
    end else begin
      cnt++;
      if (instr_done === 1'b1) begin
        tests++;
        if (lat_q.size() == 0) begin
          fails++;
          $display("FAIL latency got=%0d exp=none", cnt);
        end else begin
          lat_v = lat_q.pop_front();
          if (cnt != lat_v) begin
            fails++;
            $display("FAIL latency got=%0d exp=%0d", cnt, lat_v);
          end
        end
        cnt = 0;
      end
    end
    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL exp_drain got=%0d exp=0", exp_q.size());
      end
      tests++;
      if (lat_q.size() != 0) begin
        fails++;
        $display("FAIL lat_drain got=%0d exp=0", lat_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

endmodule
